// File: rtl/maquina_estado_mascota.sv
// Pet state arbiter: merges the four need levels and reaction flags into one
// registered state, runs the 1 s tick and the starvation-to-death timer.
module maquina_estado_mascota #(
  parameter int CICLOS_SEG    = 50000000,
  parameter int TIEMPO_MUERTE = 10,
  parameter int UMBRAL_BAJO   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] nivel_hambre,
  input  logic [1:0] nivel_sueno,
  input  logic [1:0] nivel_diversion,
  input  logic [1:0] nivel_salud,
  input  logic [3:0] reaccion,
  input  logic       pausa,
  output logic [2:0] estado,
  output logic       activo,
  output logic       alerta,
  output logic       tick_seg
);

  typedef enum logic [2:0] {
    NEUTRAL    = 3'd0,
    FELIZ      = 3'd1,
    TRISTE     = 3'd2,
    CANSADO    = 3'd3,
    HAMBRIENTO = 3'd4,
    ENFERMO    = 3'd5,
    REACCION   = 3'd6,
    MUERTO     = 3'd7
  } estado_t;

  localparam int CW = (CICLOS_SEG > 1) ? $clog2(CICLOS_SEG) : 1;
  localparam int ZW = (TIEMPO_MUERTE > 0) ? $clog2(TIEMPO_MUERTE + 1) : 1;
  localparam logic [CW-1:0] CICLO_FIN = CW'(CICLOS_SEG - 1);
  localparam logic [ZW-1:0] CERO_FIN  = ZW'(TIEMPO_MUERTE);
  localparam logic [1:0]    UMBRAL    = 2'(UMBRAL_BAJO);

  estado_t         estado_reg, estado_next;
  logic [CW-1:0]   cnt_ciclos_reg;
  logic [ZW-1:0]   cnt_cero_reg;
  logic            cero, muerto, fin_seg, corriendo;

  assign cero      = (nivel_hambre == 2'd0) | (nivel_sueno == 2'd0) |
                     (nivel_diversion == 2'd0) | (nivel_salud == 2'd0);
  assign muerto    = (estado_reg == MUERTO);
  assign fin_seg   = (cnt_ciclos_reg == CICLO_FIN);
  // Game time only advances while not paused and the pet is alive.
  assign corriendo = ~pausa & ~muerto;
  assign estado    = estado_reg;

  always_comb begin
    estado_next = estado_reg;
    if (muerto || pausa) begin
      estado_next = estado_reg;
    end else if (cnt_cero_reg == CERO_FIN) begin
      estado_next = MUERTO;
    end else if (|reaccion) begin
      estado_next = REACCION;
    end else if (nivel_salud <= UMBRAL) begin
      estado_next = ENFERMO;
    end else if (nivel_hambre <= UMBRAL) begin
      estado_next = HAMBRIENTO;
    end else if (nivel_sueno <= UMBRAL) begin
      estado_next = CANSADO;
    end else if (nivel_diversion <= UMBRAL) begin
      estado_next = TRISTE;
    end else if ((nivel_salud == 2'd3) && (nivel_hambre == 2'd3) &&
                 (nivel_sueno == 2'd3) && (nivel_diversion == 2'd3)) begin
      estado_next = FELIZ;
    end else begin
      estado_next = NEUTRAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg     <= NEUTRAL;
      activo         <= 1'b1;
      alerta         <= 1'b0;
      tick_seg       <= 1'b0;
      cnt_ciclos_reg <= '0;
      cnt_cero_reg   <= '0;
    end else begin
      estado_reg <= estado_next;
      activo     <= ~pausa & (estado_next != MUERTO);
      alerta     <= cero & (estado_next != MUERTO);
      tick_seg   <= corriendo & fin_seg;
      if (corriendo) begin
        cnt_ciclos_reg <= fin_seg ? '0 : cnt_ciclos_reg + CW'(1);
        // Any healthy cycle restarts the starvation timer; it saturates at the limit.
        if (!cero) begin
          cnt_cero_reg <= '0;
        end else if (fin_seg && (cnt_cero_reg != CERO_FIN)) begin
          cnt_cero_reg <= cnt_cero_reg + ZW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maquina_estado_mascota.sv
// Directed bench for maquina_estado_mascota with CICLOS_SEG=4, TIEMPO_MUERTE=3.
module tb_maquina_estado_mascota;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] nivel_hambre, nivel_sueno, nivel_diversion, nivel_salud;
  logic [3:0] reaccion;
  logic       pausa;
  logic [2:0] estado;
  logic       activo, alerta, tick_seg;

  int checks = 0;
  int errors = 0;

  maquina_estado_mascota #(
    .CICLOS_SEG(4),
    .TIEMPO_MUERTE(3),
    .UMBRAL_BAJO(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .nivel_hambre(nivel_hambre),
    .nivel_sueno(nivel_sueno),
    .nivel_diversion(nivel_diversion),
    .nivel_salud(nivel_salud),
    .reaccion(reaccion),
    .pausa(pausa),
    .estado(estado),
    .activo(activo),
    .alerta(alerta),
    .tick_seg(tick_seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s obs=%0d", tag, obs);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic levels(input logic [1:0] h, input logic [1:0] s,
                        input logic [1:0] d, input logic [1:0] sa);
    nivel_hambre = h; nivel_sueno = s; nivel_diversion = d; nivel_salud = sa;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    levels(2'd3, 2'd3, 2'd3, 2'd3);
    reaccion = 4'd0;
    pausa = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    levels(2'd3, 2'd3, 2'd3, 2'd3);
    reaccion = 4'd0;
    pausa = 1'b0;
    step(2);
    check("rst_estado", 8'(estado), 8'd0);
    check("rst_activo", 8'(activo), 8'd1);
    check("rst_alerta", 8'(alerta), 8'd0);
    check("rst_tick", 8'(tick_seg), 8'd0);
    reset = 1'b0;

    // E1..E8: happy pet, tick at E4 and E8
    step(1);
    check("feliz_estado", 8'(estado), 8'd1);
    check("feliz_activo", 8'(activo), 8'd1);
    check("tick_e1", 8'(tick_seg), 8'd0);
    step(2);
    check("tick_e3", 8'(tick_seg), 8'd0);
    step(1);
    check("tick_e4", 8'(tick_seg), 8'd1);
    step(1);
    check("tick_e5", 8'(tick_seg), 8'd0);
    step(3);
    check("tick_e8", 8'(tick_seg), 8'd1);

    // Priority ladder
    levels(2'd1, 2'd3, 2'd3, 2'd1);
    step(1);
    check("prio_enfermo", 8'(estado), 8'd5);
    levels(2'd1, 2'd3, 2'd3, 2'd3);
    step(1);
    check("prio_hambriento", 8'(estado), 8'd4);
    levels(2'd3, 2'd1, 2'd3, 2'd3);
    step(1);
    check("prio_cansado", 8'(estado), 8'd3);
    levels(2'd3, 2'd3, 2'd1, 2'd3);
    step(1);
    check("prio_triste", 8'(estado), 8'd2);
    check("tick_e12", 8'(tick_seg), 8'd1);
    levels(2'd2, 2'd3, 2'd3, 2'd3);
    step(1);
    check("prio_neutral", 8'(estado), 8'd0);
    check("neutral_alerta", 8'(alerta), 8'd0);
    levels(2'd3, 2'd3, 2'd3, 2'd3);
    step(3);
    check("feliz_e16", 8'(estado), 8'd1);
    check("tick_e16", 8'(tick_seg), 8'd1);

    // Death by sleep=0: counts at E20, E24, E28 -> MUERTO at E29
    levels(2'd3, 2'd0, 2'd3, 2'd3);
    step(1);
    check("cero_alerta", 8'(alerta), 8'd1);
    check("cero_estado", 8'(estado), 8'd3);
    step(11);
    check("pre_muerte_estado", 8'(estado), 8'd3);
    check("pre_muerte_activo", 8'(activo), 8'd1);
    step(1);
    check("muerto_estado", 8'(estado), 8'd7);
    check("muerto_activo", 8'(activo), 8'd0);
    check("muerto_alerta", 8'(alerta), 8'd0);
    levels(2'd3, 2'd3, 2'd3, 2'd3);
    reaccion = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("muerto_sticky", 8'(estado), 8'd7);
      check("muerto_no_tick", 8'(tick_seg), 8'd0);
    end
    do_reset();
    check("revive_estado", 8'(estado), 8'd0);
    check("revive_activo", 8'(activo), 8'd1);

    // R1..: fun=0 twice, one healthy cycle, then needs 3 more ticks
    step(1);
    check("r1_feliz", 8'(estado), 8'd1);
    levels(2'd3, 2'd3, 2'd0, 2'd3);
    step(7);
    check("r8_triste", 8'(estado), 8'd2);
    check("r8_alerta", 8'(alerta), 8'd1);
    levels(2'd3, 2'd3, 2'd3, 2'd3);
    step(1);
    check("r9_alerta", 8'(alerta), 8'd0);
    check("r9_feliz", 8'(estado), 8'd1);
    levels(2'd3, 2'd3, 2'd0, 2'd3);
    step(4);
    check("r13_vivo", 8'(estado), 8'd2);
    step(7);
    check("r20_vivo", 8'(estado), 8'd2);
    check("r20_activo", 8'(activo), 8'd1);
    step(1);
    check("r21_muerto", 8'(estado), 8'd7);

    // S: reaction over sickness, then pause with cnt_cero=2
    do_reset();
    step(1);
    check("s1_feliz", 8'(estado), 8'd1);
    levels(2'd3, 2'd3, 2'd3, 2'd0);
    reaccion = 4'b0010;
    step(1);
    check("reaccion_estado", 8'(estado), 8'd6);
    check("reaccion_alerta", 8'(alerta), 8'd1);
    reaccion = 4'b0000;
    step(1);
    check("post_reaccion", 8'(estado), 8'd5);
    step(6);
    check("s9_enfermo", 8'(estado), 8'd5);
    pausa = 1'b1;
    step(1);
    check("pausa_activo", 8'(activo), 8'd0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step(1);
      check("pausa_tick", 8'(tick_seg), 8'd0);
      check("pausa_estado", 8'(estado), 8'd5);
      check("pausa_activo_hold", 8'(activo), 8'd0);
    end
    pausa = 1'b0;
    step(1);
    check("s30_activo", 8'(activo), 8'd1);
    check("s30_estado", 8'(estado), 8'd5);
    step(2);
    check("s32_tick", 8'(tick_seg), 8'd1);
    check("s32_estado", 8'(estado), 8'd5);
    step(1);
    check("s33_muerto", 8'(estado), 8'd7);
    check("s33_activo", 8'(activo), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maquina_estado_mascota.md
Name: maquina_estado_mascota

Overview:
- Downstream consumer of the four need-level blocks (hunger, sleep, fun, health).
- Each need block produces a 2-bit level (0..3) and a reaction pulse.
- This block arbitrates those inputs into a single registered pet state for the display/animation stage.
- It generates a 1 s tick, tracks starvation-to-death time, and drives the shared activo enable back into every need block.

Parameters:
CICLOS_SEG, 50000000, clk cycles per internal 1 s tick
TIEMPO_MUERTE, 10, consecutive seconds with any level at 0 before death
UMBRAL_BAJO, 1, level at or below which a need is considered critical

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
nivel_hambre  input  2  hunger level 0..3 from its need block
nivel_sueno  input  2  sleep level 0..3
nivel_diversion  input  2  fun level 0..3
nivel_salud  input  2  health level 0..3
reaccion  input  4  reaction flags, one per need block (senal_5seg), OR-reduced internally
pausa  input  1  level input; freezes the game while high
estado  output  3  registered pet state code
activo  output  1  enable to all need blocks
alerta  output  1  high while any level is 0
tick_seg  output  1  single-cycle 1 s strobe, for downstream animation

Behaviour:
- All state updates on posedge clk. Reset is synchronous, active-high, and highest priority.
- Reset values: estado=0 (NEUTRAL), activo=1, alerta=0, tick_seg=0, all counters 0.
- Reset asserted while in MUERTO fully revives the pet.
- State codes:
  - NEUTRAL=0, FELIZ=1, TRISTE=2, CANSADO=3
  - HAMBRIENTO=4, ENFERMO=5, REACCION=6, MUERTO=7
- Tick divider:
  - cnt_ciclos counts 0..CICLOS_SEG-1, width $clog2(CICLOS_SEG).
  - On the cycle it equals CICLOS_SEG-1: tick_seg=1 (registered) and cnt_ciclos wraps to 0.
  - While pausa=1 or in MUERTO: the counter holds and tick_seg=0.
- Death counter cnt_cero, width $clog2(TIEMPO_MUERTE+1):
  - Define cero = any nivel_* == 0.
  - On any cycle with cero=0: cnt_cero clears to 0 immediately.
  - On a tick cycle with cero=1: cnt_cero increments, saturating at TIEMPO_MUERTE.
  - When cnt_cero reaches TIEMPO_MUERTE: estado=MUERTO on the following cycle.
  - MUERTO is sticky; only reset exits it. While in MUERTO, inputs are ignored.
- State evaluation: registered, 1-cycle latency from input change to estado. Priority, highest first:
  1. MUERTO (sticky)
  2. REACCION (any reaccion bit high)
  3. ENFERMO (salud <= UMBRAL_BAJO)
  4. HAMBRIENTO (hambre <= UMBRAL_BAJO)
  5. CANSADO (sueno <= UMBRAL_BAJO)
  6. TRISTE (diversion <= UMBRAL_BAJO)
  7. FELIZ (all four levels == 3)
  8. NEUTRAL (otherwise)
- Simultaneous conditions resolve strictly by this priority. Example: reaction plus health 0 gives REACCION, while cnt_cero keeps counting.
- pausa=1:
  - estado holds its current value.
  - cnt_ciclos and cnt_cero freeze; cnt_cero does not clear.
  - activo=0.
- activo is registered: activo = ~pausa & (estado_next != MUERTO).
  - Drops in the same cycle estado becomes MUERTO.
  - Drops one cycle after pausa rises.
- alerta is registered: alerta = cero & (estado_next != MUERTO). It is 0 while dead.
- Levels are unsigned. No arithmetic is performed on levels, comparisons only.

Test Plan:
- Bench parameters: CICLOS_SEG=4, TIEMPO_MUERTE=3.
- Reset, then all levels=3, reaccion=0, pausa=0 → estado=1 after 1 cycle; activo=1; tick_seg pulses every 4 cycles.
- hambre=1, salud=1, others 3 → estado=5 (ENFERMO), not 4. Then set salud=3 → estado=4 one cycle later.
- sueno=0 held → alerta=1 next cycle; after 3 ticks (about 12 cycles) estado=7, activo=0, alerta=0. Changing levels back to 3 keeps estado=7. Then reset=1 for 1 cycle → estado=0, activo=1.
- diversion=0 for 2 ticks, then diversion=3 for 1 cycle, then 0 again → cnt_cero restarts. No death until 3 further ticks.
- reaccion=4'b0010 while salud=0 → estado=6; after reaccion falls → estado=5.
- pausa=1 mid-count with cnt_cero=2, held for 20 cycles → no tick_seg, estado unchanged, activo=0. Release pausa → death occurs on the next tick.
